// File: rtl/regfile_clearable_if.sv
// ---------------------------------------------------------------------------
// regfile_clearable_if
// Bus bundle for the clearable register file.
//   clear_req             : request to zero every register
//   write_en/addr/data/strb : byte-masked write port
//   addr_a, addr_b        : read addresses
//   data_a, data_b        : combinational read data
//   ready                 : file is idle and serving reads/writes
//   write_drop            : sticky flag, a write was discarded while not ready
// master = requester side, slave = register file side.
// ---------------------------------------------------------------------------
interface regfile_clearable_if #(
   parameter int WORDSIZE = 64,
   parameter int ADDR_W   = 5
);
   logic                  clear_req;
   logic                  write_en;
   logic [ADDR_W-1:0]     write_addr;
   logic [WORDSIZE-1:0]   write_data;
   logic [WORDSIZE/8-1:0] write_strb;
   logic [ADDR_W-1:0]     addr_a;
   logic [ADDR_W-1:0]     addr_b;
   logic [WORDSIZE-1:0]   data_a;
   logic [WORDSIZE-1:0]   data_b;
   logic                  ready;
   logic                  write_drop;

   modport master (
      output clear_req, write_en, write_addr, write_data, write_strb,
      output addr_a, addr_b,
      input  data_a, data_b, ready, write_drop
   );

   modport slave (
      input  clear_req, write_en, write_addr, write_data, write_strb,
      input  addr_a, addr_b,
      output data_a, data_b, ready, write_drop
   );
endinterface

// File: rtl/regfile_clearable.sv
// ---------------------------------------------------------------------------
// regfile_clearable
// SIZE x WORDSIZE register file with two combinational read ports, one
// byte-masked write port and a sequential clear engine that zeroes one
// register per cycle. The file is unavailable (ready=0, reads return 0,
// writes dropped) while a clear runs.
// Ports:
//   clk : clock, all state updates on the rising edge
//   rst : synchronous active-high reset, restarts the clear engine
//   rf  : regfile_clearable_if.slave bus (see interface header)
// ---------------------------------------------------------------------------
module regfile_clearable #(
   parameter int WORDSIZE = 64,
   parameter int SIZE     = 32,
   parameter int ADDR_W   = 5,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input logic                clk,
   input logic                rst,
   regfile_clearable_if.slave rf
);

   localparam int NBYTES = WORDSIZE / 8;
   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(SIZE - 1);

   typedef enum logic [0:0] {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   cnt_q, cnt_d;
   logic                write_drop_q, write_drop_d;

   logic [WORDSIZE-1:0] mem_q [SIZE];
   logic                mem_we_d;
   logic [ADDR_W-1:0]   mem_waddr_d;
   logic [WORDSIZE-1:0] mem_wdata_d;

   logic                is_zero_waddr_s;
   logic [WORDSIZE-1:0] wr_mask_s;
   logic [WORDSIZE-1:0] wr_merged_s;
   logic                wr_take_s;
   logic [ADDR_W-1:0]   rd_addr_s [2];
   logic [WORDSIZE-1:0] rd_data_s [2];

   // Expand the per-byte strobe into a per-bit mask.
   function automatic logic [WORDSIZE-1:0] strb_to_mask(input logic [NBYTES-1:0] strb);
      logic [WORDSIZE-1:0] mask;
      mask = {WORDSIZE{1'b0}};
      for (int k = 0; k < NBYTES; k++) begin
         mask[8*k +: 8] = {8{strb[k]}};
      end
      return mask;
   endfunction

   // Write-port decode: hardwired zero register and byte-merged write value.
   always_comb begin
      is_zero_waddr_s = (ZERO_REG != 0) && (rf.write_addr == {ADDR_W{1'b0}});
      wr_mask_s       = strb_to_mask(rf.write_strb);
      wr_merged_s     = (mem_q[rf.write_addr] & ~wr_mask_s) | (rf.write_data & wr_mask_s);
      // An all-zero strobe is a no-op, so it never needs a storage write.
      wr_take_s       = (state_q == ST_READY) && rf.write_en && !is_zero_waddr_s
                        && (rf.write_strb != {NBYTES{1'b0}});
   end

   // Next-state, clear counter, drop flag and storage write-port selection.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      write_drop_d = write_drop_q;
      mem_we_d     = 1'b0;
      mem_waddr_d  = cnt_q;
      mem_wdata_d  = {WORDSIZE{1'b0}};
      if (rst) begin
         state_d      = ST_CLEAR;
         cnt_d        = {ADDR_W{1'b0}};
         write_drop_d = 1'b0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               // One register per cycle; clear_req is deliberately ignored here.
               mem_we_d    = 1'b1;
               mem_waddr_d = cnt_q;
               mem_wdata_d = {WORDSIZE{1'b0}};
               cnt_d       = cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
               if (cnt_q == LAST_IDX) begin
                  state_d = ST_READY;
               end else begin
                  state_d = ST_CLEAR;
               end
               if (rf.write_en && !is_zero_waddr_s) begin
                  write_drop_d = 1'b1;
               end else begin
                  write_drop_d = write_drop_q;
               end
            end
            ST_READY: begin
               if (wr_take_s) begin
                  mem_we_d    = 1'b1;
                  mem_waddr_d = rf.write_addr;
                  mem_wdata_d = wr_merged_s;
               end else begin
                  mem_we_d    = 1'b0;
               end
               if (rf.clear_req) begin
                  state_d = ST_CLEAR;
                  cnt_d   = {ADDR_W{1'b0}};
               end else begin
                  state_d = ST_READY;
               end
            end
            default: begin
               state_d = ST_CLEAR;
               cnt_d   = {ADDR_W{1'b0}};
            end
         endcase
      end
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      write_drop_q <= write_drop_d;
   end

   // Storage array; contents are only meaningful once a clear has completed.
   always_ff @(posedge clk) begin
      if (mem_we_d) begin
         mem_q[mem_waddr_d] <= mem_wdata_d;
      end
   end

   // Read ports: gated while clearing, zero register, optional write forwarding.
   always_comb begin
      rd_addr_s[0] = rf.addr_a;
      rd_addr_s[1] = rf.addr_b;
      for (int p = 0; p < 2; p++) begin
         rd_data_s[p] = {WORDSIZE{1'b0}};
         if (state_q != ST_READY) begin
            rd_data_s[p] = {WORDSIZE{1'b0}};
         end else if ((ZERO_REG != 0) && (rd_addr_s[p] == {ADDR_W{1'b0}})) begin
            rd_data_s[p] = {WORDSIZE{1'b0}};
         end else if ((BYPASS != 0) && rf.write_en && !is_zero_waddr_s
                      && (rf.write_addr == rd_addr_s[p])) begin
            rd_data_s[p] = wr_merged_s;
         end else begin
            rd_data_s[p] = mem_q[rd_addr_s[p]];
         end
      end
   end

   assign rf.data_a     = rd_data_s[0];
   assign rf.data_b     = rd_data_s[1];
   assign rf.ready      = (state_q == ST_READY);
   assign rf.write_drop = write_drop_q;

endmodule

// File: doc/regfile_clearable.md
REGFILE_CLEARABLE -- requirements
Module: regfile_clearable

Interface
REQ-001 Parameter: WORDSIZE, 64, register width in bits; SHALL be a multiple of 8.
REQ-002 Parameter: SIZE, 32, number of registers; SHALL be a power of two, at least 2.
REQ-003 Parameter: ADDR_W, 5, address width; SHALL equal log2(SIZE).
REQ-004 Parameter: ZERO_REG, 1, when 1 register 0 SHALL read as zero and ignore writes.
REQ-005 Parameter: BYPASS, 1, when 1 same-cycle write data SHALL be forwarded to read ports.
REQ-006 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-007 rst  in  1  reset, synchronous, active-high.
REQ-008 clear_req  in  1  request to zero all registers; single-cycle pulse or level.
REQ-009 write_en  in  1  write enable.
REQ-010 write_addr  in  ADDR_W  destination register.
REQ-011 write_data  in  WORDSIZE  write value.
REQ-012 write_strb  in  WORDSIZE/8  byte-enable mask; bit k gates bits [8k+7:8k].
REQ-013 addr_a, addr_b  in  ADDR_W each  read addresses.
REQ-014 data_a, data_b  out  WORDSIZE each  read data, combinational from addresses.
REQ-015 ready  out  1  high when the file accepts writes and returns valid reads.
REQ-016 write_drop  out  1  sticky flag: a write arrived while ready was low.

Function
REQ-017 FSM states: CLEAR, READY.
REQ-018 rst high at a clock edge: state SHALL go to CLEAR and clear counter SHALL go to 0, whatever the current state.
REQ-019 CLEAR: each cycle, register[counter] SHALL be written with 0 and counter SHALL increment.
REQ-020 CLEAR: the cycle that clears register SIZE-1 SHALL transition to READY; a full clear takes SIZE cycles.
REQ-021 READY with clear_req=1 at a clock edge: SHALL go to CLEAR with counter=0.
REQ-022 clear_req SHALL be ignored in CLEAR; a clear in progress is not restarted or extended.
REQ-023 ready SHALL equal 1 exactly when the state is READY (registered).
REQ-024 READY with write_en=1: bytes of register[write_addr] with strb bit set SHALL take write_data; other bytes SHALL be unchanged.
REQ-025 ZERO_REG=1: write_addr=0 SHALL have no effect and SHALL NOT set write_drop.
REQ-026 write_en=1 while ready=0: the write SHALL be discarded and write_drop SHALL be set on the next edge.
REQ-027 write_drop SHALL clear only on rst.
REQ-028 ready=0: data_a and data_b SHALL be 0.
REQ-029 ready=1: data_x SHALL equal register[addr_x], combinational (zero-cycle latency).
REQ-030 ZERO_REG=1: addr_x=0 SHALL return 0.
REQ-031 BYPASS=1, ready=1, write_en=1, write_addr=addr_x, and not the zero register: data_x SHALL be the byte-merged write result in the same cycle.
REQ-032 BYPASS=0: data_x SHALL return the pre-write value until the next edge.
REQ-033 addr_a=addr_b: both ports SHALL return identical data.
REQ-034 write_strb=0 with write_en=1: SHALL be a no-op and SHALL NOT set write_drop when ready=1.
REQ-035 Counter SHALL be ADDR_W bits wide.
REQ-036 Counter wrap after SIZE-1 SHALL coincide with the CLEAR-to-READY transition.

Reset
REQ-037 While rst=1: state SHALL be CLEAR, counter=0, ready=0, write_drop=0, and data_a=data_b=0.
REQ-038 Register contents SHALL be undefined only until the clear completes; all SHALL be 0 once ready rises.
REQ-039 After rst falls, ready SHALL rise after exactly SIZE clock edges (default 32).
REQ-040 A clear interrupted by rst or a mid-clear reset SHALL restart at counter 0 with no partial READY.

Verification
REQ-041 Power-up: rst=1 for 2 cycles, then 0 -> ready=0 for 32 edges, ready=1 on edge 32; addresses 0..31 read 0.
REQ-042 Byte write: write reg 5 = 0x1122334455667788 with strb=0xFF, then reg 5 = 0x00000000000000AA with strb=0x01 -> reg 5 reads 0x11223344556677AA.
REQ-043 Bypass: write_en=1, write_addr=7, data=0xDEAD, addr_a=7 in the same cycle -> data_a=0xDEAD before the edge; with BYPASS=0, data_a shows the old value.
REQ-044 Zero register: write reg 0 = 0xFFFF -> data_a(addr 0)=0 and write_drop stays 0.
REQ-045 Dropped write: pulse clear_req, then write reg 3 on the next cycle -> write_drop=1; after ready rises, reg 3 reads 0.
REQ-046 Mid-clear reset: assert rst at clear cycle 10 -> counter restarts at 0; ready rises 32 edges after rst falls.
